mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WD, default 32, giving the address, write-data and read-data width.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  pipeline flush; cancels delivery of the outstanding instruction fetch.
REQ-006 inst_req / inst_addr  input  1 / DATA_WD  fetch request and its address.
REQ-007 inst_addr_ok / inst_data_ok / inst_rdata  output  1 / 1 / DATA_WD  fetch accepted, fetch data valid, fetch data.
REQ-008 data_req / data_wr / data_size / data_wstrb / data_addr / data_wdata  input  1 / 1 / 2 / 4 / DATA_WD / DATA_WD  load/store request fields.
REQ-009 data_addr_ok / data_data_ok / data_rdata  output  1 / 1 / DATA_WD  data request accepted, response valid, load data.
REQ-010 bus_req / bus_wr / bus_size / bus_wstrb / bus_addr / bus_wdata  output  1 / 1 / 2 / 4 / DATA_WD / DATA_WD  shared memory bus request.
REQ-011 bus_addr_ok / bus_data_ok / bus_rdata  input  1 / 1 / DATA_WD  bus accept, bus response, bus read data.
REQ-012 stallreq_inst / stallreq_data  output  1 / 1  stall requests feeding the pipeline stall vector.

Function
REQ-013 FSM states SHALL be IDLE, REQ and WAIT, with at most one bus transaction outstanding.
REQ-014 In IDLE, when any request is high, the block SHALL grant one requester, latch its fields into owner registers, pulse that requester's addr_ok for one cycle, and go to REQ next cycle.
REQ-015 Without the macro, grant SHALL be fixed priority: data over inst.
REQ-016 In REQ, bus_req SHALL be 1 and all bus_* fields SHALL come from the latched registers, held stable until bus_addr_ok.
REQ-017 REQ with bus_addr_ok=1 SHALL go to WAIT next cycle, with bus_req=0 from then on.
REQ-018 In WAIT, bus_data_ok=1 SHALL pulse the owner's data_ok in the same cycle, with rdata=bus_rdata, and the FSM SHALL return to IDLE.
REQ-019 Minimum transaction is 3 cycles (IDLE grant, REQ, WAIT); no new grant SHALL occur in the cycle data_ok is returned.
REQ-020 Inst fetches SHALL force bus_wr=0, bus_wstrb=0 and bus_size=2'b10.
REQ-021 Data requests SHALL pass wr, size and wstrb unchanged.
REQ-022 flush while the owner is inst in REQ or WAIT SHALL set a discard flag; the transaction still completes on the bus, and inst_data_ok SHALL be suppressed for it.
REQ-023 flush in the IDLE grant cycle for inst SHALL also set the discard flag.
REQ-024 Data transactions SHALL never be discarded by flush.
REQ-025 stallreq_data SHALL be 1 when data_req is high and no data_data_ok is pulsing this cycle, or when the data owner is in REQ/WAIT without bus_data_ok.
REQ-026 stallreq_inst SHALL be defined the same way for inst, excluding discarded fetches.
REQ-027 A bus_data_ok arriving in IDLE or REQ SHALL be ignored.
REQ-028 rdata outputs SHALL be 0 whenever their data_ok is 0.

Reset
REQ-029 Reset SHALL force FSM=IDLE and clear the discard flag, the owner registers and last_grant.
REQ-030 After reset, every output SHALL be 0.
REQ-031 Reset asserted mid-transaction SHALL abandon that transaction with no data_ok pulse.

Configuration
REQ-032 Macro MEM_ARB_RR_EN SHALL be the single compile-time option.
REQ-033 With MEM_ARB_RR_EN defined, simultaneous inst and data requests SHALL be granted round-robin using a 1-bit last_grant register, with data winning first after reset.
REQ-034 With MEM_ARB_RR_EN undefined, grant SHALL be fixed data priority and last_grant SHALL be absent.

Structure
REQ-035 A shared package SHALL hold the state encoding constants (IDLE/REQ/WAIT), the size codes (byte 00, half 01, word 10) and the owner codes (INST/DATA).
REQ-036 Grant logic SHALL be one sub-module, mem_arb_grant: combinational priority or round-robin selection plus the last_grant register.

Verification
REQ-037 Scenario 1: data_req store with addr 0x1000, wdata 0xDEADBEEF, wstrb 4'hF; bus_addr_ok 1 cycle later -> bus_wr=1 with the same fields and data_data_ok after bus_data_ok; total 3 cycles.
REQ-038 Scenario 2: inst_req and data_req in the same cycle -> data granted first, inst granted in the IDLE after data_ok; with MEM_ARB_RR_EN, a second collision grants inst.
REQ-039 Scenario 3: inst fetch addr 0x1C000000 with flush in WAIT, bus_rdata 0x12345678 -> inst_data_ok stays 0, FSM returns to IDLE.
REQ-040 Scenario 4: bus_addr_ok held low for 5 cycles -> bus_req and bus fields stable for all 5, stallreq of the owner high throughout.
REQ-041 Scenario 5: reset asserted in WAIT, bus_data_ok the next cycle -> no data_ok pulse, all outputs 0, FSM in IDLE.
REQ-042 Scenario 6: ld.b at addr 0x2003 -> bus_size=00 and bus_addr=0x2003, data_rdata equals bus_rdata unchanged.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the instruction/data memory bus arbiter.
// Holds the FSM state encoding, the bus size codes and the owner codes.
// Imported by mem_arb_grant and mem_bus_arbiter.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection between the fetch and load/store requesters.
// Combinational grant; with MEM_ARB_RR_EN defined, collisions alternate via last_grant_q.
// Ports: clk/reset, grant_en (arbiter idle), inst_req/data_req in; gnt_vld/gnt_owner out.
module mem_arb_grant
    import mem_bus_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   grant_en,
    input  logic   inst_req,
    input  logic   data_req,
    output logic   gnt_vld,
    output owner_e gnt_owner
);

    assign gnt_vld = grant_en & (inst_req | data_req);

`ifdef MEM_ARB_RR_EN
    owner_e last_grant_q;
    owner_e last_grant_d;
    logic   collide;

    assign collide = inst_req & data_req;

    // last_grant_q only remembers collision outcomes; its reset value
    // (INST) lets data win the first collision.
    always_comb begin
        gnt_owner    = data_req ? OWN_DATA : OWN_INST;
        last_grant_d = last_grant_q;
        if (collide) begin
            gnt_owner = (last_grant_q == OWN_DATA) ? OWN_INST : OWN_DATA;
        end
        if (grant_en && collide) begin
            last_grant_d = gnt_owner;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= OWN_INST;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    // Fixed priority needs no state.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
    assign gnt_owner      = data_req ? OWN_DATA : OWN_INST;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates fetch and load/store requests onto one memory bus, one transaction at a time.
// Ports: inst_* / data_* requester sides, bus_* shared bus, flush, stallreq_* to the pipeline.
// Optional macro MEM_ARB_RR_EN selects round-robin on collisions (default: data priority).
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int DATA_WD = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               inst_req,
    input  logic [DATA_WD-1:0] inst_addr,
    output logic               inst_addr_ok,
    output logic               inst_data_ok,
    output logic [DATA_WD-1:0] inst_rdata,
    input  logic               data_req,
    input  logic               data_wr,
    input  logic [1:0]         data_size,
    input  logic [3:0]         data_wstrb,
    input  logic [DATA_WD-1:0] data_addr,
    input  logic [DATA_WD-1:0] data_wdata,
    output logic               data_addr_ok,
    output logic               data_data_ok,
    output logic [DATA_WD-1:0] data_rdata,
    output logic               bus_req,
    output logic               bus_wr,
    output logic [1:0]         bus_size,
    output logic [3:0]         bus_wstrb,
    output logic [DATA_WD-1:0] bus_addr,
    output logic [DATA_WD-1:0] bus_wdata,
    input  logic               bus_addr_ok,
    input  logic               bus_data_ok,
    input  logic [DATA_WD-1:0] bus_rdata,
    output logic               stallreq_inst,
    output logic               stallreq_data
);

    arb_state_e         state_q, state_d;
    owner_e             owner_q, owner_d;
    logic               wr_q, wr_d;
    logic [1:0]         size_q, size_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic [DATA_WD-1:0] addr_q, addr_d;
    logic [DATA_WD-1:0] wdata_q, wdata_d;
    logic               discard_q, discard_d;

    logic   grant_en;
    logic   gnt_vld;
    owner_e gnt_owner;
    logic   busy;
    logic   txn_done;
    logic   discard_now;

    // No grant while reset is held so nothing is accepted that reset would drop.
    assign grant_en = (state_q == ST_IDLE) && !reset;

    mem_arb_grant u_grant (
        .clk       (clk),
        .reset     (reset),
        .grant_en  (grant_en),
        .inst_req  (inst_req),
        .data_req  (data_req),
        .gnt_vld   (gnt_vld),
        .gnt_owner (gnt_owner)
    );

    assign busy     = (state_q != ST_IDLE);
    assign txn_done = (state_q == ST_WAIT) && bus_data_ok && !reset;
    // A flush in the completing cycle itself must also swallow the fetch.
    assign discard_now = discard_q || (busy && (owner_q == OWN_INST) && flush);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        wr_d      = wr_q;
        size_d    = size_q;
        wstrb_d   = wstrb_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        discard_d = discard_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    state_d = ST_REQ;
                    owner_d = gnt_owner;
                    if (gnt_owner == OWN_DATA) begin
                        wr_d      = data_wr;
                        size_d    = data_size;
                        wstrb_d   = data_wstrb;
                        addr_d    = data_addr;
                        wdata_d   = data_wdata;
                        discard_d = 1'b0;
                    end else begin
                        wr_d      = 1'b0;
                        size_d    = SIZE_WORD;
                        wstrb_d   = 4'h0;
                        addr_d    = inst_addr;
                        wdata_d   = '0;
                        discard_d = flush;
                    end
                end
            end
            ST_REQ: begin
                if (flush && (owner_q == OWN_INST)) discard_d = 1'b1;
                if (bus_addr_ok) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (flush && (owner_q == OWN_INST)) discard_d = 1'b1;
                if (bus_data_ok) begin
                    state_d   = ST_IDLE;
                    discard_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_INST;
            wr_q      <= 1'b0;
            size_q    <= 2'b00;
            wstrb_q   <= 4'h0;
            addr_q    <= '0;
            wdata_q   <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            wr_q      <= wr_d;
            size_q    <= size_d;
            wstrb_q   <= wstrb_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            discard_q <= discard_d;
        end
    end

    assign inst_addr_ok = gnt_vld && (gnt_owner == OWN_INST);
    assign data_addr_ok = gnt_vld && (gnt_owner == OWN_DATA);
    assign inst_data_ok = txn_done && (owner_q == OWN_INST) && !discard_now;
    assign data_data_ok = txn_done && (owner_q == OWN_DATA);
    assign inst_rdata   = inst_data_ok ? bus_rdata : '0;
    assign data_rdata   = data_data_ok ? bus_rdata : '0;

    // Bus fields are driven only while the request is being presented.
    assign bus_req   = (state_q == ST_REQ);
    assign bus_wr    = bus_req ? wr_q    : 1'b0;
    assign bus_size  = bus_req ? size_q  : 2'b00;
    assign bus_wstrb = bus_req ? wstrb_q : 4'h0;
    assign bus_addr  = bus_req ? addr_q  : '0;
    assign bus_wdata = bus_req ? wdata_q : '0;

    assign stallreq_data = (data_req && !data_data_ok)
                         || (busy && (owner_q == OWN_DATA) && !txn_done);
    assign stallreq_inst = (inst_req && !inst_data_ok)
                         || (busy && (owner_q == OWN_INST) && !discard_now && !txn_done);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios then random traffic.
// A transaction-level reference model predicts every output each cycle.
// Honours MEM_ARB_RR_EN for the collision expectation.
module tb_mem_bus_arbiter;

    localparam int DW = 32;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, flush;
    logic          inst_req;
    logic [DW-1:0] inst_addr;
    logic          inst_addr_ok, inst_data_ok;
    logic [DW-1:0] inst_rdata;
    logic          data_req, data_wr;
    logic [1:0]    data_size;
    logic [3:0]    data_wstrb;
    logic [DW-1:0] data_addr, data_wdata;
    logic          data_addr_ok, data_data_ok;
    logic [DW-1:0] data_rdata;
    logic          bus_req, bus_wr;
    logic [1:0]    bus_size;
    logic [3:0]    bus_wstrb;
    logic [DW-1:0] bus_addr, bus_wdata;
    logic          bus_addr_ok, bus_data_ok;
    logic [DW-1:0] bus_rdata;
    logic          stallreq_inst, stallreq_data;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.DATA_WD(DW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .stallreq_inst(stallreq_inst), .stallreq_data(stallreq_data)
    );

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    // Reference model: one in-flight transaction record.
    bit          m_busy, m_acc, m_owner_data, m_disc, m_last_data;
    bit          m_wr;
    bit [1:0]    m_size;
    bit [3:0]    m_wstrb;
    bit [DW-1:0] m_addr, m_wdata;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit data_wins();
        return data_req && (!inst_req || !RR || !m_last_data);
    endfunction

    task automatic clr_in();
        reset = 0; flush = 0; inst_req = 0; inst_addr = '0;
        data_req = 0; data_wr = 0; data_size = 2'b00; data_wstrb = 4'h0;
        data_addr = '0; data_wdata = '0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;
    endtask

    // Compare every DUT output with the model's prediction for this cycle.
    task automatic at_neg();
        bit gnt, wd, done, disc;
        bit e_iaok, e_daok, e_idok, e_ddok, e_breq, e_si, e_sd;
        @(negedge clk);
        gnt    = !m_busy && !reset && (inst_req || data_req);
        wd     = data_wins();
        done   = m_busy && m_acc && bus_data_ok && !reset;
        disc   = m_disc || (m_busy && !m_owner_data && flush);
        e_iaok = gnt && !wd;
        e_daok = gnt && wd;
        e_idok = done && !m_owner_data && !disc;
        e_ddok = done && m_owner_data;
        e_breq = m_busy && !m_acc;
        e_si   = (inst_req && !e_idok) || (m_busy && !m_owner_data && !disc && !done);
        e_sd   = (data_req && !e_ddok) || (m_busy && m_owner_data && !done);
        chk("handshake",
            {89'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, stallreq_inst, stallreq_data, bus_req},
            {89'd0, e_iaok, e_idok, e_daok, e_ddok, e_si, e_sd, e_breq});
        if (e_breq)
            chk("bus_fields", {25'd0, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata},
                {25'd0, m_wr, m_size, m_wstrb, m_addr, m_wdata});
        else
            chk("bus_idle", {25'd0, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata}, 96'd0);
        chk("rdata", {32'd0, inst_rdata, data_rdata},
            {32'd0, e_idok ? bus_rdata : 32'd0, e_ddok ? bus_rdata : 32'd0});
    endtask

    task automatic advance();
        bit wd;
        @(posedge clk);
        cyc++;
        if (reset) begin
            m_busy = 0; m_acc = 0; m_owner_data = 0; m_disc = 0; m_last_data = 0;
            m_wr = 0; m_size = 0; m_wstrb = 0; m_addr = 0; m_wdata = 0;
        end else if (!m_busy) begin
            if (inst_req || data_req) begin
                wd = data_wins();
                if (inst_req && data_req) m_last_data = wd;
                m_busy = 1; m_acc = 0; m_owner_data = wd;
                if (wd) begin
                    m_wr = data_wr; m_size = data_size; m_wstrb = data_wstrb;
                    m_addr = data_addr; m_wdata = data_wdata; m_disc = 0;
                end else begin
                    m_wr = 0; m_size = 2'b10; m_wstrb = 0;
                    m_addr = inst_addr; m_wdata = 0; m_disc = flush;
                end
            end
        end else begin
            if (!m_owner_data && flush) m_disc = 1;
            if (!m_acc) begin
                if (bus_addr_ok) m_acc = 1;
            end else if (bus_data_ok) begin
                m_busy = 0; m_disc = 0;
            end
        end
        #1;
    endtask

    task automatic tick();
        at_neg();
        advance();
    endtask

    int g_cyc, d_cyc;
    logic [DW-1:0] rd;

    initial begin
        clr_in();
        reset = 1;
        tick(); tick();
        clr_in();
        at_neg();
        chk("reset_outputs", {7'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok,
                              stallreq_inst, stallreq_data, bus_req, bus_wr, bus_size, bus_wstrb,
                              bus_addr[15:0], bus_wdata[15:0], inst_rdata, data_rdata}, 96'd0);
        advance();

        // Scenario 1: word store, accepted next cycle, 3-cycle transaction.
        data_req = 1; data_wr = 1; data_size = 2'b10; data_wstrb = 4'hF;
        data_addr = 32'h1000; data_wdata = 32'hDEADBEEF;
        at_neg(); chk("s1_addr_ok", data_addr_ok, 1); g_cyc = cyc; advance();
        clr_in(); bus_addr_ok = 1;
        at_neg();
        chk("s1_bus", {bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata}, {1'b1, 1'b1, 4'hF, 32'h1000, 32'hDEADBEEF});
        advance();
        clr_in(); bus_data_ok = 1; bus_rdata = $urandom;
        at_neg(); chk("s1_data_ok", data_data_ok, 1); d_cyc = cyc; advance();
        chk("s1_latency", d_cyc - g_cyc + 1, 3);
        clr_in(); tick();

        // Scenario 2: collision, data first, inst granted after data_ok.
        inst_req = 1; inst_addr = 32'h400; data_req = 1; data_addr = 32'h800; data_size = 2'b10;
        at_neg(); chk("s2_first", {inst_addr_ok, data_addr_ok}, 2'b01); advance();
        data_req = 0; bus_addr_ok = 1; tick();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hCAFE0001;
        at_neg(); chk("s2_no_grant_on_done", {inst_addr_ok, data_data_ok}, 2'b01); advance();
        bus_data_ok = 0;
        at_neg(); chk("s2_inst_next", inst_addr_ok, 1); advance();
        inst_req = 0; bus_addr_ok = 1; tick();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h0BADF00D;
        at_neg(); chk("s2_inst_done", inst_rdata, 32'h0BADF00D); advance();
        clr_in();
        inst_req = 1; data_req = 1;
        at_neg(); chk("s2_second_collision", {inst_addr_ok, data_addr_ok}, RR ? 2'b10 : 2'b01); advance();
        clr_in(); bus_addr_ok = 1; tick();
        clr_in(); bus_data_ok = 1; tick();
        clr_in(); tick();

        // Scenario 3: flushed fetch completes on the bus but is not delivered.
        inst_req = 1; inst_addr = 32'h1C000000;
        tick();
        inst_req = 0; bus_addr_ok = 1; tick();
        clr_in(); flush = 1; tick();
        clr_in(); bus_data_ok = 1; bus_rdata = 32'h12345678;
        at_neg(); chk("s3_suppressed", {inst_data_ok, stallreq_inst, inst_rdata}, 34'd0); advance();
        clr_in(); inst_req = 1; inst_addr = 32'h1C000004;
        at_neg(); chk("s3_back_idle", inst_addr_ok, 1); advance();
        inst_req = 0; bus_addr_ok = 1; tick();
        clr_in(); bus_data_ok = 1; bus_rdata = 32'h55AA55AA;
        at_neg(); chk("s3_discard_cleared", inst_data_ok, 1); advance();
        clr_in();

        // Scenario 4: bus_addr_ok withheld for five cycles.
        data_req = 1; data_wr = 1; data_size = 2'b01; data_wstrb = 4'h3;
        data_addr = 32'h3000; data_wdata = 32'h0000BEEF;
        tick();
        clr_in();
        for (int i = 0; i < 5; i++) begin
            at_neg();
            chk("s4_hold", {bus_req, stallreq_data, bus_size, bus_wstrb, bus_addr, bus_wdata},
                {1'b1, 1'b1, 2'b01, 4'h3, 32'h3000, 32'h0000BEEF});
            advance();
        end
        bus_addr_ok = 1; tick();
        clr_in(); bus_data_ok = 1; tick();
        clr_in();

        // Scenario 6: byte load at an odd address, rdata passed through.
        data_req = 1; data_size = 2'b00; data_addr = 32'h2003;
        tick();
        clr_in(); bus_addr_ok = 1;
        at_neg(); chk("s6_bus", {bus_size, bus_wr, bus_addr}, {2'b00, 1'b0, 32'h2003}); advance();
        clr_in(); bus_data_ok = 1; rd = $urandom; bus_rdata = rd;
        at_neg(); chk("s6_rdata", data_rdata, rd); advance();
        clr_in();

        // Scenario 5: reset in WAIT abandons the transaction.
        data_req = 1; data_addr = 32'h4000; data_size = 2'b10;
        tick();
        clr_in(); bus_addr_ok = 1; tick();
        clr_in(); reset = 1; tick();
        clr_in(); bus_data_ok = 1; bus_rdata = 32'hFFFFFFFF;
        at_neg();
        chk("s5_all_zero", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, stallreq_inst,
                            stallreq_data, bus_req, bus_wr, bus_size, bus_wstrb, inst_rdata, data_rdata},
            {7'd0, 1'b0, 2'b00, 4'h0, 32'd0, 32'd0});
        advance();
        clr_in(); tick();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 63) == 0);
            flush       = ($urandom_range(0, 7) == 0);
            inst_req    = ($urandom_range(0, 2) == 0);
            data_req    = ($urandom_range(0, 2) == 0);
            inst_addr   = $urandom;
            data_wr     = $urandom_range(0, 1);
            data_size   = 2'($urandom_range(0, 2));
            data_wstrb  = 4'($urandom);
            data_addr   = $urandom;
            data_wdata  = $urandom;
            bus_addr_ok = $urandom_range(0, 1);
            bus_data_ok = $urandom_range(0, 1);
            bus_rdata   = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
